// File: rtl/frogger_game_ctrl_if.sv
// Signal bundle between the Frogger sequencer and its neighbours (buttons, lane generator, renderer).
// master drives raw buttons and lane bitmaps; slave is the sequencer driving game status.
interface frogger_game_ctrl_if;
   logic       up;
   logic       down;
   logic       left;
   logic       right;
   logic       start;
   logic [7:0] lane1;
   logic [7:0] lane2;
   logic [7:0] lane3;
   logic [7:0] lane5;
   logic [7:0] lane6;
   logic       lane_step;
   logic [2:0] frog_row;
   logic [7:0] frog_col;
   logic [2:0] lives;
   logic [7:0] score;
   logic [2:0] level;
   logic [2:0] game_state;

   modport master (
      output up, down, left, right, start, lane1, lane2, lane3, lane5, lane6,
      input  lane_step, frog_row, frog_col, lives, score, level, game_state
   );

   modport slave (
      input  up, down, left, right, start, lane1, lane2, lane3, lane5, lane6,
      output lane_step, frog_row, frog_col, lives, score, level, game_state
   );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger sequencer: debounced buttons, frog position, lives/score/level, lane pacing, collision FSM.
// Latency: raw button edge moves the frog 2 + DEBOUNCE_CYCLES + 1 cycles later; a hit is taken on the next edge.
// Backpressure: none, free-running; presses outside their state are dropped. Option: FROGGER_LEVEL_SPEEDUP_EN.
module frogger_game_ctrl #(
   parameter int unsigned STEP_CYCLES     = 100_000_000,
   parameter int unsigned MIN_STEP_CYCLES = 12_500_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HOLD_CYCLES     = 50_000_000,
   parameter int unsigned LIVES           = 3
) (
   input  logic               clk,
   input  logic               reset,
   frogger_game_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PLAY = 3'd1,
      ST_HIT  = 3'd2,
      ST_WIN  = 3'd3,
      ST_OVER = 3'd4
   } state_t;

   localparam int                DEB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [27:0]       STEP_BASE  = 28'(STEP_CYCLES);
   localparam logic [27:0]       STEP_MIN   = 28'(MIN_STEP_CYCLES);
   localparam logic [26:0]       HOLD_LAST  = 27'(HOLD_CYCLES - 1);
   localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
   localparam logic [2:0]        HOME_ROW   = 3'd7;
   localparam logic [7:0]        HOME_COL   = 8'b0001_0000;

   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_START = 4;

   logic [4:0]            btn_raw;
   logic [4:0]            btn_meta;
   logic [4:0]            btn_sync;
   logic [4:0]            btn_stable;
   logic [4:0]            press;
   logic [4:0][DEB_W-1:0] deb_cnt;

   state_t      state, state_nxt;
   logic [2:0]  frog_row, frog_row_nxt;
   logic [7:0]  frog_col, frog_col_nxt;
   logic [2:0]  lives, lives_nxt;
   logic [7:0]  score, score_nxt;
   logic [2:0]  level, level_nxt;
   logic        lane_step, lane_step_nxt;
   logic [27:0] step_cnt, step_cnt_nxt;
   logic [27:0] step_last;
   logic [26:0] hold_cnt, hold_cnt_nxt;
   logic [7:0]  lane_row;
   logic        collide;

   assign btn_raw = {bus.start, bus.right, bus.left, bus.down, bus.up};

   // Buttons idle high; a press strobe fires only when the accepted level falls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_meta   <= '1;
         btn_sync   <= '1;
         btn_stable <= '1;
         press      <= '0;
         deb_cnt    <= '0;
      end else begin
         btn_meta <= btn_raw;
         btn_sync <= btn_meta;
         for (int i = 0; i < 5; i++) begin
            press[i] <= 1'b0;
            if (btn_sync[i] == btn_stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               deb_cnt[i]    <= '0;
               btn_stable[i] <= btn_sync[i];
               press[i]      <= ~btn_sync[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef FROGGER_LEVEL_SPEEDUP_EN
   logic [27:0] step_shift;
   assign step_shift = STEP_BASE >> level;
   assign step_last  = ((step_shift < STEP_MIN) ? STEP_MIN : step_shift) - 28'd1;
`else
   assign step_last  = ((STEP_BASE < STEP_MIN) ? STEP_MIN : STEP_BASE) - 28'd1;
`endif

   // Rows 0, 4 and 7 have no traffic.
   always_comb begin
      lane_row = 8'h00;
      case (frog_row)
         3'd1:    lane_row = bus.lane1;
         3'd2:    lane_row = bus.lane2;
         3'd3:    lane_row = bus.lane3;
         3'd5:    lane_row = bus.lane5;
         3'd6:    lane_row = bus.lane6;
         default: lane_row = 8'h00;
      endcase
   end

   assign collide = |(lane_row & frog_col);

   always_comb begin
      state_nxt     = state;
      frog_row_nxt  = frog_row;
      frog_col_nxt  = frog_col;
      lives_nxt     = lives;
      score_nxt     = score;
      level_nxt     = level;
      lane_step_nxt = 1'b0;
      step_cnt_nxt  = '0;
      hold_cnt_nxt  = '0;
      case (state)
         ST_IDLE, ST_OVER: begin
            if (press[BTN_START]) begin
               state_nxt    = ST_PLAY;
               frog_row_nxt = HOME_ROW;
               frog_col_nxt = HOME_COL;
               lives_nxt    = LIVES_INIT;
               score_nxt    = '0;
               level_nxt    = '0;
            end
         end
         ST_PLAY: begin
            if (frog_row == 3'd0) begin
               state_nxt = ST_WIN;
               score_nxt = (score == 8'hFF) ? score : score + 8'd1;
               level_nxt = (level == 3'd7)  ? level : level + 3'd1;
            end else if (collide) begin
               state_nxt = ST_HIT;
               lives_nxt = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            end else begin
               if (step_cnt == step_last) begin
                  lane_step_nxt = 1'b1;
               end else begin
                  step_cnt_nxt = step_cnt + 28'd1;
               end
               // One move per cycle; a blocked higher-priority move still consumes the slot.
               if (press[BTN_UP]) begin
                  if (frog_row != 3'd0) frog_row_nxt = frog_row - 3'd1;
               end else if (press[BTN_DOWN]) begin
                  if (frog_row != 3'd7) frog_row_nxt = frog_row + 3'd1;
               end else if (press[BTN_LEFT]) begin
                  if (!frog_col[7]) frog_col_nxt = frog_col << 1;
               end else if (press[BTN_RIGHT]) begin
                  if (!frog_col[0]) frog_col_nxt = frog_col >> 1;
               end
            end
         end
         ST_HIT: begin
            if (hold_cnt == HOLD_LAST) begin
               if (lives == 3'd0) begin
                  state_nxt = ST_OVER;
               end else begin
                  state_nxt    = ST_PLAY;
                  frog_row_nxt = HOME_ROW;
                  frog_col_nxt = HOME_COL;
               end
            end else begin
               hold_cnt_nxt = hold_cnt + 27'd1;
            end
         end
         ST_WIN: begin
            if (hold_cnt == HOLD_LAST) begin
               state_nxt    = ST_PLAY;
               frog_row_nxt = HOME_ROW;
               frog_col_nxt = HOME_COL;
            end else begin
               hold_cnt_nxt = hold_cnt + 27'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         frog_row  <= HOME_ROW;
         frog_col  <= HOME_COL;
         lives     <= LIVES_INIT;
         score     <= '0;
         level     <= '0;
         lane_step <= 1'b0;
         step_cnt  <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         frog_row  <= frog_row_nxt;
         frog_col  <= frog_col_nxt;
         lives     <= lives_nxt;
         score     <= score_nxt;
         level     <= level_nxt;
         lane_step <= lane_step_nxt;
         step_cnt  <= step_cnt_nxt;
         hold_cnt  <= hold_cnt_nxt;
      end
   end

   assign bus.lane_step  = lane_step;
   assign bus.frog_row   = frog_row;
   assign bus.frog_col   = frog_col;
   assign bus.lives      = lives;
   assign bus.score      = score;
   assign bus.level      = level;
   assign bus.game_state = state;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: directed timing checks plus randomized presses against a transaction-level game model.
module tb_frogger_game_ctrl;
   localparam int D    = 4;
   localparam int HOLD = 8;
   localparam int STEP = 16;
   localparam int MINS = 4;
   localparam int NL   = 3;
   localparam int SETTLE = D + 2 + HOLD + 6;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   frogger_game_ctrl_if bus ();

   frogger_game_ctrl #(
      .STEP_CYCLES(STEP), .MIN_STEP_CYCLES(MINS), .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES(HOLD), .LIVES(NL)
   ) dut (
      .clk(clk), .reset(rst_n), .bus(bus)
   );

   int n_chk, n_fail;
   int m_row, m_lives, m_score, m_level, m_state;
   logic [7:0] m_col;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btns(input logic [4:0] v);
      {bus.start, bus.right, bus.left, bus.down, bus.up} = v;
   endtask

   task automatic drive_btn(input logic [4:0] m, input int len);
      set_btns(~m);
      cyc(len);
      set_btns(5'b11111);
   endtask

   function automatic logic [7:0] lane_of(input int row);
      case (row)
         1: return bus.lane1;
         2: return bus.lane2;
         3: return bus.lane3;
         5: return bus.lane5;
         6: return bus.lane6;
         default: return 8'h00;
      endcase
   endfunction

   function automatic int exp_period(input int lvl);
      int p;
`ifdef FROGGER_LEVEL_SPEEDUP_EN
      p = STEP >> lvl;
      if (p < MINS) p = MINS;
`else
      p = STEP;
`endif
      return p;
   endfunction

   task automatic model_reset();
      m_state = 0; m_row = 7; m_col = 8'h10; m_lives = NL; m_score = 0; m_level = 0;
   endtask

   // Outcome of one settled press under the game rules.
   task automatic model_press(input logic [4:0] m, input int len);
      if (len < D) return;
      if (m_state == 0 || m_state == 4) begin
         if (m[4]) begin
            m_state = 1; m_row = 7; m_col = 8'h10; m_lives = NL; m_score = 0; m_level = 0;
         end
         return;
      end
      if (m[0])      begin if (m_row > 0) m_row = m_row - 1; end
      else if (m[1]) begin if (m_row < 7) m_row = m_row + 1; end
      else if (m[2]) begin if (!m_col[7]) m_col = m_col << 1; end
      else if (m[3]) begin if (!m_col[0]) m_col = m_col >> 1; end
      if (m_row == 0) begin
         if (m_score < 255) m_score = m_score + 1;
         if (m_level < 7)   m_level = m_level + 1;
         m_row = 7; m_col = 8'h10;
      end else if ((lane_of(m_row) & m_col) != 8'h00) begin
         m_lives = m_lives - 1;
         if (m_lives == 0) m_state = 4;
         else begin m_row = 7; m_col = 8'h10; end
      end
   endtask

   task automatic compare_model(input string tag);
      chk({tag, "_row"},   int'(bus.frog_row),   m_row);
      chk({tag, "_col"},   int'(bus.frog_col),   int'(m_col));
      chk({tag, "_lives"}, int'(bus.lives),      m_lives);
      chk({tag, "_score"}, int'(bus.score),      m_score);
      chk({tag, "_level"}, int'(bus.level),      m_level);
      chk({tag, "_state"}, int'(bus.game_state), m_state);
   endtask

   task automatic do_press(input logic [4:0] m, input int len, input string tag);
      drive_btn(m, len);
      model_press(m, len);
      cyc(SETTLE);
      compare_model(tag);
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_lane_step"}, int'(bus.lane_step),  0);
      chk({pfx, "_row"},       int'(bus.frog_row),   7);
      chk({pfx, "_col"},       int'(bus.frog_col),   'h10);
      chk({pfx, "_lives"},     int'(bus.lives),      NL);
      chk({pfx, "_score"},     int'(bus.score),      0);
      chk({pfx, "_level"},     int'(bus.level),      0);
      chk({pfx, "_state"},     int'(bus.game_state), 0);
   endtask

   task automatic wait_state(input int s, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (int'(bus.game_state) == s) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_row(input int r, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (int'(bus.frog_row) == r) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic measure_step(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.lane_step && n < 200);
   endtask

   task automatic count_steps(input int cycles, output int hi);
      hi = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.lane_step) hi++;
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1, "watchdog");
   end

   int n, hi, len, sel;
   bit ok;
   logic [4:0] m;

   initial begin
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0;
      set_btns(5'b11111);
      bus.lane1 = 8'h00; bus.lane2 = 8'h00; bus.lane3 = 8'h00; bus.lane5 = 8'h00; bus.lane6 = 8'h00;
      model_reset();
      cyc(3);
      chk_reset("reset");
      rst_n = 1'b1;
      count_steps(40, hi);
      chk("idle_lane_step", hi, 0);
      chk("idle_state", int'(bus.game_state), 0);

      // start press and lane pacing
      drive_btn(5'b10000, 6);
      wait_state(1, ok);
      chk("start_seen", int'(ok), 1);
      model_press(5'b10000, 6);
      measure_step(n);
      chk("first_step", n, STEP);
      measure_step(n);
      chk("step_period", n, STEP);
      compare_model("after_start");

      // bounce rejection and single move per press
      do_press(5'b01000, 2, "bounce");
      chk("bounce_col", int'(bus.frog_col), 'h10);
      do_press(5'b01000, 10, "press10");
      chk("press10_col", int'(bus.frog_col), 'h08);
      cyc(20);
      compare_model("no_repeat");

      // playfield edges
      repeat (3) do_press(5'b01000, 5, "right_walk");
      chk("right_reach", int'(bus.frog_col), 'h01);
      do_press(5'b01000, 5, "right_edge");
      chk("right_edge_col", int'(bus.frog_col), 'h01);
      repeat (7) do_press(5'b00100, 5, "left_walk");
      chk("left_reach", int'(bus.frog_col), 'h80);
      do_press(5'b00100, 5, "left_edge");
      chk("left_edge_col", int'(bus.frog_col), 'h80);
      do_press(5'b00010, 5, "bottom_edge");
      chk("bottom_edge_row", int'(bus.frog_row), 7);
      do_press(5'b00101, 5, "up_left");
      chk("up_left_row", int'(bus.frog_row), 6);
      chk("up_left_col", int'(bus.frog_col), 'h80);

      // reach the goal
      repeat (5) do_press(5'b00001, 5, "goal_climb");
      drive_btn(5'b00001, 6);
      wait_state(3, ok);
      chk("win_seen", int'(ok), 1);
      chk("win_score", int'(bus.score), 1);
      chk("win_level", int'(bus.level), 1);
      model_press(5'b00001, 6);
      cyc(SETTLE);
      compare_model("after_win");
      measure_step(n);
      measure_step(n);
      chk("win_period", n, exp_period(m_level));

      // three hits end the game
      bus.lane1 = 8'hFF;
      for (int h = 0; h < 3; h++) begin
         repeat (5) do_press(5'b00001, 5, "hit_climb");
         drive_btn(5'b00001, 6);
         wait_row(1, ok);
         chk("row1_seen", int'(ok), 1);
         model_press(5'b00001, 6);
         @(negedge clk);
         chk("hit_state", int'(bus.game_state), 2);
         chk("hit_lives", int'(bus.lives), 2 - h);
         cyc(HOLD - 1);
         chk("hit_hold_state", int'(bus.game_state), 2);
         cyc(1);
         if (h < 2) begin
            chk("hit_home_row", int'(bus.frog_row), 7);
            chk("hit_replay_state", int'(bus.game_state), 1);
         end else begin
            chk("over_state", int'(bus.game_state), 4);
            chk("over_row", int'(bus.frog_row), 1);
         end
         cyc(D + 4);
         compare_model("after_hit");
      end
      count_steps(40, hi);
      chk("over_lane_step", hi, 0);
      do_press(5'b00001, 5, "over_discard");

      // randomized play
      for (int t = 0; t < 150; t++) begin
         if (m_row == 7) begin
            bus.lane1 = 8'($urandom) & 8'($urandom);
            bus.lane2 = 8'($urandom) & 8'($urandom);
            bus.lane3 = 8'($urandom) & 8'($urandom);
            bus.lane5 = 8'($urandom) & 8'($urandom);
            bus.lane6 = 8'($urandom) & 8'($urandom);
         end
         sel = int'($urandom_range(0, 6));
         case (sel)
            0, 1:    m = 5'b00001;
            2:       m = 5'b00010;
            3:       m = 5'b00100;
            4:       m = 5'b01000;
            5:       m = 5'b10000;
            default: m = {1'b0, 4'($urandom_range(1, 15))};
         endcase
         if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, D - 1));
         else                           len = int'($urandom_range(D, D + 6));
         do_press(m, len, $sformatf("rnd%0d", t));
      end

      // asynchronous reset in the middle of a hit hold
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      model_reset();
      bus.lane1 = 8'hFF; bus.lane2 = 8'h00; bus.lane3 = 8'h00; bus.lane5 = 8'h00; bus.lane6 = 8'h00;
      cyc(3);
      do_press(5'b10000, 5, "rs_start");
      repeat (5) do_press(5'b00001, 5, "rs_climb");
      drive_btn(5'b00001, 6);
      wait_state(2, ok);
      chk("rs_hit_seen", int'(ok), 1);
      cyc(3);
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_hit");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(3);
      chk("post_rst_state", int'(bus.game_state), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/frogger_game_ctrl.md
# frogger_game_ctrl

Game sequencer for the Frogger display path. Debounces the four active-low direction buttons and a start button, owns frog position, lives, score and level, and issues the lane-advance strobe that paces the car-lane shifters. It checks the frog against the lane bitmaps and runs the play / hit / win / game-over state machine. Outputs feed the VGA renderer and the lane generator.

## Interface
- STEP_CYCLES, 100_000_000: base clock cycles between lane_step pulses at level 0.
- MIN_STEP_CYCLES, 12_500_000: floor on the step period.
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button must stay stable to be accepted.
- HOLD_CYCLES, 50_000_000: dwell time in HIT and WIN.
- LIVES, 3: lives at game start, range 1..7.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- up, down, left, right  in  1 each  raw buttons, active-low.
- start  in  1  raw start button, active-low.
- lane1, lane2, lane3, lane5, lane6  in  8 each  car bitmaps for rows 1–3 and 5–6. Bit 7 is the leftmost column.
- lane_step  out  1  one-cycle pulse that advances the lanes.
- frog_row  out  3  row 0 is the goal and row 7 is the start.
- frog_col  out  8  one-hot column. Bit 7 is the leftmost column.
- lives  out  3  remaining lives.
- score  out  8  number of goals reached, saturating at 255.
- level  out  3  speed level, saturating at 7.
- game_state  out  3  0 IDLE, 1 PLAY, 2 HIT, 3 WIN, 4 OVER.

## Operation
- Every button goes through a 2-flop synchronizer, then a debounce counter.
- A press is the debounced high-to-low transition. It produces a one-cycle internal strobe, so each press gives exactly one move.
- Frog home position: frog_row=7, frog_col=8'b0001_0000.
- IDLE: frog at home, lane_step held at 0. A start press clears score and level, loads lives=LIVES, and moves to PLAY.
- PLAY, step counter: counts to the current period. It emits lane_step for one cycle and reloads.
- PLAY, moves: one move per cycle, with priority up > down > left > right.
  - up: frog_row-1, ignored at row 0.
  - down: frog_row+1, ignored at row 7.
  - left: frog_col<<1, ignored when bit 7 is set.
  - right: frog_col>>1, ignored when bit 0 is set.
- PLAY, collision: checked every cycle against the registered frog position and lane inputs. If frog_row ∈ {1,2,3,5,6} and (lane_row & frog_col) != 0, go to HIT. Rows 0, 4 and 7 are safe.
- PLAY, goal: frog_row==0 goes to WIN. A collision the same cycle cannot occur because row 0 is safe.
- HIT: on entry, lives decrements. Stay HOLD_CYCLES.
  - If lives==0, go to OVER.
  - Otherwise return the frog home and go to PLAY.
- WIN: on entry, score increments and level increments, both saturating. Stay HOLD_CYCLES, then return the frog home and go to PLAY.
- OVER: the frog stays where it was hit and lane_step is 0. A start press reinitializes exactly as IDLE does and goes to PLAY.
- In HIT, WIN and OVER, button presses are discarded. The step counter is cleared and restarts from 0 on re-entry to PLAY.
- In PLAY, a start press is ignored.

## Timing
- Reset values: lane_step=0, frog_row=7, frog_col=8'b0001_0000, lives=LIVES, score=0, level=0, game_state=0. All debounce, step and hold counters are 0.
- Reset is asynchronous and takes effect mid-game, mid-hold or mid-debounce. The first edge after release samples from these values.
- Press latency: a raw low edge updates frog_row/frog_col 2 sync cycles + DEBOUNCE_CYCLES + 1 cycles later.
- Collision latency: the state becomes HIT on the edge after the overlap is visible on the registered inputs. lives decrements on that same edge.
- A move and a lane_step in the same cycle both take effect. The collision check uses the following cycle's values.
- lane_step is registered and high for exactly one cycle per period.
- Counter widths: 28-bit step counter and 27-bit hold counter. The step counter compares with ==, so there is no wrap.
- Bounce shorter than DEBOUNCE_CYCLES is rejected. A held button produces no repeat.

## Configuration
- FROGGER_LEVEL_SPEEDUP_EN defined: step period = max(STEP_CYCLES >> level, MIN_STEP_CYCLES).
- FROGGER_LEVEL_SPEEDUP_EN undefined: step period = STEP_CYCLES at every level. level is still counted and output.

## Test plan
Bench parameters: STEP_CYCLES=16, MIN_STEP_CYCLES=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, LIVES=3.
- Reset release, then a start press: game_state goes 0→1, lives=3, first lane_step 16 cycles after entering PLAY, then every 16 cycles.
- right pulsed low for 2 cycles, then low for 10 cycles: no move from the 2-cycle bounce. The 10-cycle press moves frog_col 0001_0000→0000_1000 once, with no repeat.
- Frog moved to column 8'b0000_0001, then right pressed: frog_col stays 8'b0000_0001. Same check at the left and top/bottom edges.
- lane1=8'hFF and frog moved up to row 1: HIT on the next cycle, lives 3→2, frog home after 8 cycles. Three such hits end in game_state=4 with lives=0.
- Frog driven up to row 0 with lanes clear: WIN, score=1, level=1, return to PLAY. With the macro defined the step period is 8; without it the period is 16.
- up and left pressed on the same cycle: only frog_row decrements. Reset asserted during HIT hold: all outputs immediately take their reset values.
